// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of a simple dual-port BRAM (port A write, port B read)
// with a 2-entry output buffer that hides the BRAM read latency.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_BITS+1:0]  level_o,
  output logic                  mem_en_a_o,
  output logic                  mem_we_a_o,
  output logic [ADDR_BITS-1:0]  mem_addr_a_o,
  output logic [DATA_WIDTH-1:0] mem_data_a_o,
  output logic                  mem_en_b_o,
  output logic [ADDR_BITS-1:0]  mem_addr_b_o,
  input  logic [DATA_WIDTH-1:0] mem_data_b_i
);

  // Word count of a completely full BRAM (DEPTH = 2**ADDR_BITS).
  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] CNT_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [ADDR_BITS:0]    mem_cnt;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_nxt;
  logic                  infl;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;

  logic       wr_fire;
  logic       pop;
  logic       issue;
  logic [2:0] occ;

  assign wr_ready_o = (mem_cnt < DEPTH_CNT) && !flush_i;
  // Port A stays quiet while reset is asserted even if the writer is pushing.
  assign wr_fire    = wr_valid_i && wr_ready_o && arstn_i;
  assign pop        = rd_valid_o && rd_ready_i;

  // A read may be issued only if the buffer will still have a free slot when the
  // BRAM data lands, counting the word already in flight and this cycle's pop.
  // mem_cnt only counts words written at earlier edges, so rd_ptr never equals
  // the port A address of the same cycle.
  assign occ   = {1'b0, buf_cnt} + {2'b00, infl};
  assign issue = (mem_cnt != '0) && (occ < (3'd2 + {2'b00, pop})) && !flush_i;

  assign mem_en_a_o   = wr_fire;
  assign mem_we_a_o   = wr_fire;
  assign mem_addr_a_o = wr_ptr;
  assign mem_data_a_o = wr_data_i;

  assign mem_en_b_o   = issue;
  assign mem_addr_b_o = rd_ptr;

  assign rd_valid_o = valid_q;
  assign rd_data_o  = buf_head;
  assign level_o    = {1'b0, mem_cnt} + {{(ADDR_BITS+1){1'b0}}, infl}
                    + {{ADDR_BITS{1'b0}}, buf_cnt};

  // Next output-buffer occupancy: a fill and a pop together leave it unchanged.
  always_comb begin
    buf_cnt_nxt = buf_cnt;
    if (flush_i) begin
      buf_cnt_nxt = 2'd0;
    end else if (infl && !pop) begin
      buf_cnt_nxt = buf_cnt + 2'd1;
    end else if (!infl && pop) begin
      buf_cnt_nxt = buf_cnt - 2'd1;
    end
  end

  // Pointers, BRAM word count, in-flight flag and buffer occupancy.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      infl    <= 1'b0;
      buf_cnt <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      buf_cnt <= buf_cnt_nxt;
      valid_q <= (buf_cnt_nxt != 2'd0);
      infl    <= issue;
      if (flush_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        mem_cnt <= '0;
      end else begin
        if (wr_fire) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (issue) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (wr_fire && !issue) begin
          mem_cnt <= mem_cnt + CNT_ONE;
        end else if (!wr_fire && issue) begin
          mem_cnt <= mem_cnt - CNT_ONE;
        end
      end
    end
  end

  // Output buffer data: head is the oldest word, tail the next one; a returning
  // BRAM word goes into the first slot that is free after this cycle's pop.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      buf_head <= '0;
      buf_tail <= '0;
    end else if (!flush_i) begin
      if (pop) begin
        if (infl) begin
          if (buf_cnt == 2'd2) begin
            buf_head <= buf_tail;
            buf_tail <= mem_data_b_i;
          end else begin
            buf_head <= mem_data_b_i;
          end
        end else begin
          buf_head <= buf_tail;
        end
      end else if (infl) begin
        if (buf_cnt == 2'd0) begin
          buf_head <= mem_data_b_i;
        end else begin
          buf_tail <= mem_data_b_i;
        end
      end
    end
  end

endmodule

// File: doc/bram_fifo_ctrl.md
BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the word width; it SHALL equal the attached BRAM RAM_WIDTH.
REQ-002 The block SHALL have parameter ADDR_BITS, default 10, the BRAM address width; BRAM depth DEPTH = 2**ADDR_BITS.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; arstn_i  in  1  async reset, active low.
REQ-004 The block SHALL have a flush input: flush_i  in  1  synchronous clear of all contents.
REQ-005 The block SHALL have the write side: wr_valid_i in 1; wr_ready_o out 1; wr_data_i in DATA_WIDTH.
REQ-006 The block SHALL have the read side: rd_valid_o out 1; rd_ready_i in 1; rd_data_o out DATA_WIDTH.
REQ-007 The block SHALL have the status output: level_o  out  ADDR_BITS+2  total words held.
REQ-008 The block SHALL drive BRAM port A (write-only): mem_en_a_o out 1; mem_we_a_o out 1; mem_addr_a_o out ADDR_BITS; mem_data_a_o out DATA_WIDTH.
REQ-009 The block SHALL drive BRAM port B (read-only): mem_en_b_o out 1; mem_addr_b_o out ADDR_BITS; mem_data_b_i in DATA_WIDTH, registered BRAM output with 1-cycle latency that holds while en is low.

Function
REQ-010 The block SHALL keep wr_ptr, rd_ptr (ADDR_BITS, wrap DEPTH-1 -> 0) and mem_cnt (0..DEPTH, ADDR_BITS+1 bits).
REQ-011 The block SHALL drive wr_ready_o = (mem_cnt < DEPTH) and not flush_i, combinationally.
REQ-012 The block SHALL, on a write handshake, drive mem_en_a_o=mem_we_a_o=1, mem_addr_a_o=wr_ptr and mem_data_a_o=wr_data_i in the same cycle, then increment wr_ptr; otherwise port A enables SHALL be 0.
REQ-013 The block SHALL contain a 2-entry output buffer (buf_cnt 0..2) and a 1-bit in-flight flag infl.
REQ-014 The block SHALL define pop = rd_valid_o and rd_ready_i.
REQ-015 The block SHALL issue a read (mem_en_b_o=1, mem_addr_b_o=rd_ptr, rd_ptr++, mem_cnt--) when mem_cnt>0, (buf_cnt + infl - pop) < 2 and not flush_i.
REQ-016 The block SHALL set infl=1 at the edge ending an issue cycle, else 0.
REQ-017 The block SHALL, when infl=1, write mem_data_b_i into the output buffer at that edge.
REQ-018 The block SHALL drive rd_valid_o = (buf_cnt>0) and rd_data_o = the oldest buffer entry, both directly from registers.
REQ-019 The block SHALL handle a simultaneous write and issue by changing mem_cnt by net 0.
REQ-020 The block SHALL handle a simultaneous pop and buffer fill by keeping buf_cnt unchanged and keeping order.
REQ-021 The block SHALL issue reads only for addresses already written at an earlier edge, so ports A and B never collide on one address in one cycle.
REQ-022 The block SHALL give a latency of 2 cycles: a word accepted at edge E into an empty block SHALL be on rd_valid_o/rd_data_o after edge E+2.
REQ-023 The block SHALL sustain 1 word/cycle throughput in steady state with rd_ready_i held high.
REQ-024 The block SHALL compute level_o = mem_cnt + infl + buf_cnt (max DEPTH+2).
REQ-025 The block SHALL treat wr_valid_i high while full as a no-op, and SHALL NOT change wr_ptr or mem_cnt.
REQ-026 The block SHALL treat rd_ready_i while empty as a no-op.
REQ-027 The block SHALL treat rd_data_o as don't-care when rd_valid_o=0.
REQ-028 The block SHALL, on flush_i=1 at an edge, clear pointers, mem_cnt, buf_cnt and infl, and discard any in-flight BRAM data.
REQ-029 The block SHALL ignore any handshake in a cycle where flush_i=1.
REQ-030 The block SHALL treat flush_i priority as flush > write/read.

Reset
REQ-031 The block SHALL, on arstn_i=0, immediately and asynchronously clear wr_ptr, rd_ptr, mem_cnt, buf_cnt, infl and buffer data to 0.
REQ-032 The block SHALL, during reset, drive the outputs wr_ready_o=1 (flush_i=0), rd_valid_o=0, level_o=0, and all mem_en/we=0.
REQ-033 The block SHALL, on reset mid-transfer, lose all contents without recovery; BRAM contents SHALL be left as is.
REQ-034 The block SHALL operate normally from the first rising edge after arstn_i deasserts.

Verification
REQ-035 The bench SHALL cover single word: write 0xA5 at edge E, rd_ready_i=1 -> rd_valid_o=1 with 0xA5 after E+2, level_o 1 -> 0 after pop.
REQ-036 The bench SHALL cover streaming: 1000 words 0,1,2,... with both sides always ready -> in-order output, no bubble after the first word, level_o <= 3.
REQ-037 The bench SHALL cover full: ADDR_BITS=4, rd_ready_i=0, write 20 words -> wr_ready_o=0 after 18 accepted, level_o=18, then drain 18 words in order.
REQ-038 The bench SHALL cover wrap: ADDR_BITS=4, 40 words with random valid/ready -> pointers wrap, data matches the reference model, no port A/B same-address collision.
REQ-039 The bench SHALL cover flush: flush_i pulsed the cycle after a read issue (infl=1) -> next cycle level_o=0, rd_valid_o=0, and the in-flight word is never output.
REQ-040 The bench SHALL cover async reset: arstn_i low mid-stream, between edges -> rd_valid_o=0 and level_o=0 without a clock edge, and a fresh word after release arrives after 2 cycles.
